pll_rst_seq: RTL and testbench
==============================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset attempt (>=1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 256: consecutive synchronized lock cycles required before release (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65535: maximum cycles waiting for lock per attempt (>=2).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: re-attempts allowed after the first attempt before declaring failure.
REQ-005 SHALL have port refclk, input, 1: sole clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock indication, asynchronous to refclk.
REQ-008 SHALL have port sw_restart, input, 1: single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1: reset to the PLL, active-high.
REQ-010 SHALL have port sys_rst, output, 1: synchronous active-high reset for downstream logic.
REQ-011 SHALL have port ready, output, 1: PLL locked and stable, and downstream released.
REQ-012 SHALL have port fail, output, 1: retries exhausted.
REQ-013 SHALL have port retry_cnt, output, $clog2(MAX_RETRIES+1): retries used in the current sequence.
REQ-014 SHALL have port lock_loss_cnt, output, 8: count of lock losses seen in RUN, saturating at 255.

Function
REQ-015 SHALL synchronize pll_locked through two flops (reset value 0) to give locked_s, which is 2 cycles of latency; all decisions SHALL use locked_s only.
REQ-016 SHALL implement the states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAIL, with a single shared cycle counter that is cleared on every state change.
REQ-017 RESET_PLL: pll_rst=1; after exactly RST_CYCLES cycles in this state, go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0.
- If locked_s=1: go to STABLE.
- Else, after LOCK_TIMEOUT_CYCLES cycles in this state, do one of two things:
  - if retry_cnt==MAX_RETRIES: go to FAIL;
  - otherwise increment retry_cnt and go to RESET_PLL.
REQ-019 STABLE: pll_rst=0.
- If locked_s=0 in any cycle: return to WAIT_LOCK, which restarts the timeout count.
- After LOCK_STABLE_CYCLES consecutive cycles of locked_s=1: go to RUN.
REQ-020 RUN: sys_rst=0, ready=1.
- If locked_s=0: go to RESET_PLL, increment lock_loss_cnt (saturating), and clear retry_cnt.
REQ-021 FAIL: pll_rst=1, sys_rst=1, fail=1; the block SHALL stay in FAIL until sw_restart or rst.
REQ-022 sys_rst SHALL be 1 and ready SHALL be 0 in every state other than RUN.
REQ-023 All outputs SHALL be registered, i.e. decoded from the registered state.
REQ-024 Release latency: let edge t be the first edge at which locked_s=1 while in WAIT_LOCK. With lock held steady, ready SHALL rise and sys_rst SHALL fall after edge t+LOCK_STABLE_CYCLES.
REQ-025 sw_restart=1 in any state SHALL cause the next state to be RESET_PLL and SHALL clear retry_cnt.
REQ-026 sw_restart SHALL take priority over a simultaneous timeout or lock loss; in that case lock_loss_cnt is still incremented if the lock loss occurred in RUN.
REQ-027 If a timeout and locked_s=1 occur in the same cycle of WAIT_LOCK, lock SHALL win and the next state is STABLE.
REQ-028 retry_cnt SHALL never exceed MAX_RETRIES, and lock_loss_cnt SHALL hold at 255 without wrapping.

Reset
REQ-029 While rst=1, the block SHALL hold the following values:
- state=RESET_PLL and counter=0;
- pll_rst=1 and sys_rst=1;
- ready=0 and fail=0;
- retry_cnt=0 and lock_loss_cnt=0;
- synchronizer flops=0.
REQ-030 After rst is released, pll_rst SHALL remain high for exactly RST_CYCLES further cycles.
REQ-031 rst asserted mid-sequence, including in RUN or FAIL, SHALL return the block to these values on the next edge.

Verification
All scenarios use RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
REQ-032 Nominal lock:
- Stimulus: release rst, then raise pll_locked 10 cycles later.
- Response: pll_rst is high for 4 cycles after release; ready=1 and sys_rst=0 exactly 10 edges after the first sampling of pll_locked=1; retry_cnt=0.
REQ-033 Lock never arrives:
- Stimulus: pll_locked held at 0.
- Response: 3 pll_rst pulses of 4 cycles each, with retry_cnt stepping 0,1,2; fail=1 after the third 32-cycle timeout; the block stays in FAIL.
REQ-034 Glitchy lock:
- Stimulus: pll_locked high for 5 cycles, low for 1, then high.
- Response: no ready during the first window; ready occurs 8 stable cycles after the second rise.
REQ-035 Lock loss in RUN:
- Stimulus: drop pll_locked for 1 cycle.
- Response: ready falls and sys_rst rises 3 edges later; lock_loss_cnt increments by 1; pll_rst pulses for 4 cycles; the block re-locks.
- Repeating this 300 times leaves lock_loss_cnt=255.
REQ-036 Restart and reset:
- sw_restart in FAIL leads to RESET_PLL with retry_cnt=0 and fail=0.
- sw_restart on the same edge as a lock loss leads to RESET_PLL with lock_loss_cnt incremented.
- rst in RUN forces all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/pll_rst_seq.sv
// pll_rst_seq -- PLL reset / lock-qualification sequencer.
//
// Pulses pll_rst, waits for the (synchronized) lock indication, requires it to
// stay up for a qualification window, then releases sys_rst to downstream
// logic. Lock timeouts retry the PLL reset up to MAX_RETRIES times before
// parking in FAIL. Lock loss while running restarts the whole sequence.
//
// Ports
//   refclk        in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL lock, asynchronous to refclk
//   sw_restart    in   single-cycle restart request (any state)
//   pll_rst       out  reset to the PLL, active-high
//   sys_rst       out  downstream synchronous reset, active-high
//   ready         out  lock stable and downstream released
//   fail          out  retries exhausted
//   retry_cnt     out  retries used in the current sequence
//   lock_loss_cnt out  lock losses seen while running, saturates at 255
module pll_rst_seq #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               sw_restart,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [7:0]                         lock_loss_cnt
);

  localparam int RW      = $clog2(MAX_RETRIES+1);
  localparam int CNT_MAX = (RST_CYCLES > LOCK_STABLE_CYCLES)
                         ? ((RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_CYCLES : LOCK_TIMEOUT_CYCLES)
                         : ((LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES);
  localparam int CW      = $clog2(CNT_MAX+1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sync1, r_sync2;
  logic [RW-1:0]   r_retry;
  logic [7:0]      r_loss;
  logic            r_pll_rst, r_sys_rst, r_ready, r_fail;

  state_t          w_nxt;
  logic            w_locked_s;
  logic            w_retry_inc;
  logic            w_loss;

  assign w_locked_s = r_sync2;
  // Lock loss is counted even when sw_restart overrides the transition.
  assign w_loss     = (r_state == S_RUN) && !w_locked_s;

  always_comb begin
    w_nxt       = r_state;
    w_retry_inc = 1'b0;
    case (r_state)
      S_RESET_PLL: if (r_cnt == CW'(RST_CYCLES-1)) w_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        // Lock is checked first so it wins over a same-cycle timeout.
        if (w_locked_s) w_nxt = S_STABLE;
        else if (r_cnt == CW'(LOCK_TIMEOUT_CYCLES-1)) begin
          if (r_retry == RW'(MAX_RETRIES)) w_nxt = S_FAIL;
          else begin
            w_nxt       = S_RESET_PLL;
            w_retry_inc = 1'b1;
          end
        end
      end
      S_STABLE: begin
        if (!w_locked_s) w_nxt = S_WAIT_LOCK;
        else if (r_cnt == CW'(LOCK_STABLE_CYCLES-1)) w_nxt = S_RUN;
      end
      S_RUN:   if (!w_locked_s) w_nxt = S_RESET_PLL;
      S_FAIL:  w_nxt = S_FAIL;
      default: w_nxt = S_RESET_PLL;
    endcase
    if (sw_restart) w_nxt = S_RESET_PLL;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= S_RESET_PLL;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
      r_state <= w_nxt;
      // A restart re-enters RESET_PLL, so the count starts over even if the
      // state value itself does not change.
      if ((w_nxt != r_state) || sw_restart) r_cnt <= '0;
      else if (r_cnt != CW'(CNT_MAX))       r_cnt <= r_cnt + CW'(1);
      if (sw_restart || w_loss) r_retry <= '0;
      else if (w_retry_inc)     r_retry <= r_retry + RW'(1);
      if (w_loss && (r_loss != 8'hFF)) r_loss <= r_loss + 8'd1;
      // Outputs decoded from the next state so they track r_state exactly.
      r_pll_rst <= (w_nxt == S_RESET_PLL) || (w_nxt == S_FAIL);
      r_sys_rst <= (w_nxt != S_RUN);
      r_ready   <= (w_nxt == S_RUN);
      r_fail    <= (w_nxt == S_FAIL);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign fail          = r_fail;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with RST_CYCLES=4, LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2. Expected values are hand-derived
// edge counts; inputs change and outputs are sampled 1 ns after posedge.
module tb_pll_rst_seq;
  localparam int RC = 4, LS = 8, LT = 32, MR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1, pll_locked = 1'b0, sw_restart = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  int         checks = 0, errors = 0;

  always #5 refclk = ~refclk;

  pll_rst_seq #(
    .RST_CYCLES(RC), .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT_CYCLES(LT), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_restart(sw_restart),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
    chk({tag, "_ready"},   32'(ready), 0);
    chk({tag, "_fail"},    32'(fail), 0);
    chk({tag, "_retry"},   32'(retry_cnt), 0);
    chk({tag, "_llc"},     32'(lock_loss_cnt), 0);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk_rst_vals("rst");

    // Nominal lock: release at E0, pll_rst high through E3
    rst = 1'b0;
    tick(3);  chk("nom_prst_e3", 32'(pll_rst), 1);
    tick(1);  chk("nom_prst_e4", 32'(pll_rst), 0);
              chk("nom_sysrst_e4", 32'(sys_rst), 1);
    tick(6);  pll_locked = 1'b1;          // first sampled at E11
    tick(10); chk("nom_ready_e20", 32'(ready), 0);
    tick(1);  chk("nom_ready_e21", 32'(ready), 1);
              chk("nom_sysrst_e21", 32'(sys_rst), 0);
              chk("nom_retry", 32'(retry_cnt), 0);
              chk("nom_prst_run", 32'(pll_rst), 0);

    // Single-cycle lock loss in RUN, sampled at edge s
    pll_locked = 1'b0; tick(1); pll_locked = 1'b1;
    tick(1);  chk("loss_ready_s1", 32'(ready), 1);
    tick(1);  chk("loss_ready_s2", 32'(ready), 0);
              chk("loss_sysrst_s2", 32'(sys_rst), 1);
              chk("loss_prst_s2", 32'(pll_rst), 1);
              chk("loss_llc", 32'(lock_loss_cnt), 1);
    tick(3);  chk("loss_prst_s5", 32'(pll_rst), 1);
    tick(1);  chk("loss_prst_s6", 32'(pll_rst), 0);
    tick(8);  chk("loss_ready_s14", 32'(ready), 0);
    tick(1);  chk("loss_ready_s15", 32'(ready), 1);

    // 299 more losses: counter must stick at 255
    repeat (299) begin
      pll_locked = 1'b0; tick(1); pll_locked = 1'b1; tick(15);
    end
    chk("sat_llc", 32'(lock_loss_cnt), 255);
    chk("sat_ready", 32'(ready), 1);

    // rst while in RUN
    rst = 1'b1; tick(1);
    chk_rst_vals("rstrun");

    // Lock never arrives
    pll_locked = 1'b0; tick(2);
    rst = 1'b0;
    tick(35); chk("tmo_prst_e35", 32'(pll_rst), 0);
              chk("tmo_retry_e35", 32'(retry_cnt), 0);
    tick(1);  chk("tmo_prst_e36", 32'(pll_rst), 1);
              chk("tmo_retry_e36", 32'(retry_cnt), 1);
    tick(3);  chk("tmo_prst_e39", 32'(pll_rst), 1);
    tick(1);  chk("tmo_prst_e40", 32'(pll_rst), 0);
    tick(32); chk("tmo_prst_e72", 32'(pll_rst), 1);
              chk("tmo_retry_e72", 32'(retry_cnt), 2);
    tick(35); chk("tmo_fail_e107", 32'(fail), 0);
    tick(1);  chk("tmo_fail_e108", 32'(fail), 1);
              chk("tmo_prst_e108", 32'(pll_rst), 1);
              chk("tmo_sysrst_e108", 32'(sys_rst), 1);
              chk("tmo_retry_e108", 32'(retry_cnt), 2);
    tick(40); chk("tmo_fail_hold", 32'(fail), 1);
              chk("tmo_retry_hold", 32'(retry_cnt), 2);

    // sw_restart in FAIL, restart edge R0
    sw_restart = 1'b1; tick(1); sw_restart = 1'b0;
    chk("swr_fail", 32'(fail), 0);
    chk("swr_retry", 32'(retry_cnt), 0);
    chk("swr_prst", 32'(pll_rst), 1);

    // Glitchy lock: 5 high, 1 low, then high
    tick(4);  chk("gl_prst_r4", 32'(pll_rst), 0);
    pll_locked = 1'b1; tick(5);
    pll_locked = 1'b0; tick(1);
    pll_locked = 1'b1;
    tick(5);  chk("gl_ready_r15", 32'(ready), 0);
    tick(5);  chk("gl_ready_r20", 32'(ready), 0);
    tick(1);  chk("gl_ready_r21", 32'(ready), 1);

    // sw_restart on the same edge as a lock loss in RUN
    pll_locked = 1'b0; tick(1); pll_locked = 1'b1;
    tick(1);  sw_restart = 1'b1;
    tick(1);  sw_restart = 1'b0;
    chk("simul_prst", 32'(pll_rst), 1);
    chk("simul_ready", 32'(ready), 0);
    chk("simul_llc", 32'(lock_loss_cnt), 1);
    chk("simul_retry", 32'(retry_cnt), 0);

    // Lock and timeout on the same WAIT_LOCK edge (R36): lock wins
    pll_locked = 1'b0;
    tick(33); pll_locked = 1'b1;
    tick(2);  chk("race_prst_r35", 32'(pll_rst), 0);
    tick(1);  chk("race_prst_r36", 32'(pll_rst), 0);
              chk("race_retry_r36", 32'(retry_cnt), 0);
    tick(8);  chk("race_ready_r44", 32'(ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
